cpu_state_dumper: RTL
=====================

# cpu_state_dumper

Synthesizable architectural-state dump engine for the pipelined CPU. On a programmable trigger it walks the register file and then data memory through dedicated read ports and streams every word out over a valid/ready channel tagged with source and index. The testbench captures and prints this stream, so result files no longer depend on hierarchical peeks at a fixed cycle. It sits beside the CPU core, sharing `clk_i`/`rst_i`.

## Interface
Parameters:
- `DATA_W`, 32, width of register and memory words
- `RF_DEPTH`, 32, register-file entries dumped (index 0..RF_DEPTH-1)
- `DM_DEPTH`, 32, data-memory words dumped (word index 0..DM_DEPTH-1)
- `CNT_W`, 16, width of cycle counter and trigger compare
- `IDX_W`, clog2(max(RF_DEPTH,DM_DEPTH)), derived index width

Ports:
- `clk_i` in 1: single clock
- `rst_i` in 1: reset, asynchronous, active-high
- `mode_i` in 2: 0 off, 1 one-shot at cycle, 2 periodic, 3 external edge
- `trig_cycle_i` in CNT_W: compare value (mode 1) or period (mode 2)
- `trig_ext_i` in 1: external trigger level (mode 3, rising edge)
- `rf_raddr_o` out IDX_W: register-file read address
- `rf_rdata_i` in DATA_W: register-file read data, combinational to `rf_raddr_o`
- `dm_raddr_o` out IDX_W: data-memory word address
- `dm_rdata_i` in DATA_W: data-memory read data, combinational to `dm_raddr_o`
- `dump_valid_o` out 1, `dump_ready_i` in 1: stream handshake
- `dump_data_o` out DATA_W, `dump_src_o` out 1 (0 RF, 1 DM), `dump_idx_o` out IDX_W, `dump_last_o` out 1 (final DM word)
- `busy_o` out 1: scan in progress
- `done_o` out 1: one-cycle pulse after last handshake
- `overrun_o` out 1: sticky, trigger arrived while busy
- `cycle_o` out CNT_W: free-running cycle counter

## Operation
- FSM states: IDLE, RF_SCAN, DM_SCAN, FINISH.
- IDLE -> RF_SCAN on trigger. Scan index is cleared to 0.
- RF_SCAN: `rf_raddr_o` = index. An output-register load happens when `!dump_valid_o || dump_ready_i`, and the index then increments. After loading index RF_DEPTH-1, go to DM_SCAN with index 0.
- DM_SCAN: same rule on `dm_raddr_o`. Loading index DM_DEPTH-1 sets `dump_last_o` with that word and moves to FINISH.
- FINISH: wait for the handshake on the last word, then pulse `done_o` and return to IDLE.
- Trigger sources:
  - mode 1: fires once when `cycle_o == trig_cycle_i`. An armed flag is cleared on fire and re-armed by reset or by a mode change.
  - mode 2: fires when a period counter reaches `trig_cycle_i`-1, then the counter clears. A period of 0 never fires.
  - mode 3: fires on a registered rising edge of `trig_ext_i`.
- Any trigger while `busy_o` is dropped and sets `overrun_o`. Only reset clears `overrun_o`.
- `cycle_o` increments every cycle and wraps at 2^CNT_W. It runs in all modes.
- Output payload is held stable while `dump_valid_o && !dump_ready_i`.
- Addresses while IDLE are 0.

## Timing
- Reset values: all outputs 0, FSM IDLE, armed=1, `cycle_o`=0. Reset mid-scan aborts immediately with no `done_o`.
- Trigger condition true in cycle t: `busy_o`=1 at t+1, first `dump_valid_o` (RF idx 0) at t+2.
- With `dump_ready_i` held high there is one word per cycle. RF_DEPTH+DM_DEPTH words are contiguous, with no gap at the RF->DM boundary.
- `done_o` is asserted the cycle after the last handshake. `busy_o` falls in the same cycle. A new trigger is accepted from that cycle onward.
- Mode 3 edge detect adds one cycle: edge sampled at t, fire at t+1.
- Backpressure: each cycle with ready low extends the scan by exactly one cycle. No word is skipped or duplicated.

## Structure
- Shared package `dump_pkg`: FSM state enum, mode encodings (`MODE_OFF/AT/PERIOD/EXT`), source tag constants.
- One natural sub-module, `dump_trigger`: cycle counter, period counter, armed flag, edge detect. It outputs a single `fire` pulse.
- The scan FSM and output register stay in the top module.

## Test plan
- Mode 1, `trig_cycle_i`=30, ready=1, RF[i]=i, DM[i]=100+i -> first valid at cycle 32. 64 words arrive in order: RF 0..31, then DM 0..31 with data 100..131. `last` is set only on DM 31. `done_o` at cycle 96. No second dump.
- Backpressure: ready toggles 1010… during the scan -> same 64 words in order. Payload is stable while stalled. Scan takes 128 cycles.
- Mode 2, period 80 -> dumps start at fire cycles 79, 159, 239. `overrun_o` stays 0.
- Mode 2, period 40 (shorter than a 66-cycle scan) -> second fire is dropped. `overrun_o`=1 and stays 1 until reset.
- Mode 3, `trig_ext_i` pulse high for 5 cycles -> exactly one dump. A held-high level does not retrigger.
- `rst_i` asserted mid-DM_SCAN -> all outputs 0 immediately, no `done_o`. After release with mode 1 and `trig_cycle_i`=10, a fresh dump starts with RF idx 0 at cycle 12.

Source files
------------

// File: rtl/cpu_state_dumper_pkg.sv
// Shared types and constants for the architectural-state dump engine.
package dump_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RF_SCAN = 2'd1,
    DM_SCAN = 2'd2,
    FINISH  = 2'd3
  } dump_state_e;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_AT     = 2'd1,
    MODE_PERIOD = 2'd2,
    MODE_EXT    = 2'd3
  } dump_mode_e;

  localparam logic SRC_RF = 1'b0;
  localparam logic SRC_DM = 1'b1;

endpackage

// File: rtl/cpu_state_dumper_trigger.sv
// Trigger generation: free-running cycle counter, one-shot compare,
// periodic counter and registered external edge, merged into one fire pulse.
module dump_trigger
  import dump_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] trig_cycle_i,
  input  logic             trig_ext_i,
  output logic             fire_o,
  output logic [CNT_W-1:0] cycle_o
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             armed_q, armed_d;
  logic [1:0]       mode_q, mode_d;
  logic             ext_q, ext_d;
  logic             edge_q, edge_d;
  logic             fire_at, fire_per, fire_ext;

  always_comb begin
    cycle_d = cycle_q + 1'b1;
    mode_d  = mode_i;
    ext_d   = trig_ext_i;
    edge_d  = trig_ext_i & ~ext_q;

    fire_at  = (mode_i == MODE_AT) && armed_q && (cycle_q == trig_cycle_i);
    // >= rather than == so a shortened period takes effect without a wrap
    fire_per = (mode_i == MODE_PERIOD) && (trig_cycle_i != '0) &&
               (per_q >= trig_cycle_i - 1'b1);
    fire_ext = (mode_i == MODE_EXT) && edge_q;

    armed_d = armed_q;
    if (fire_at) begin
      armed_d = 1'b0;
    end else if (mode_i != mode_q) begin
      armed_d = 1'b1;
    end

    if ((mode_i != MODE_PERIOD) || fire_per) begin
      per_d = '0;
    end else begin
      per_d = per_q + 1'b1;
    end

    fire_o = fire_at | fire_per | fire_ext;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_q <= '0;
      per_q   <= '0;
      armed_q <= 1'b1;
      mode_q  <= '0;
      ext_q   <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      per_q   <= per_d;
      armed_q <= armed_d;
      mode_q  <= mode_d;
      ext_q   <= ext_d;
      edge_q  <= edge_d;
    end
  end

  assign cycle_o = cycle_q;

endmodule

// File: rtl/cpu_state_dumper.sv
// Walks the register file then data memory on a trigger and streams each
// word out over a valid/ready channel tagged with source and index.
module cpu_state_dumper
  import dump_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RF_DEPTH = 32,
  parameter int DM_DEPTH = 32,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = $clog2((RF_DEPTH > DM_DEPTH) ? RF_DEPTH : DM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        mode_i,
  input  logic [CNT_W-1:0]  trig_cycle_i,
  input  logic              trig_ext_i,
  output logic [IDX_W-1:0]  rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic [IDX_W-1:0]  dm_raddr_o,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_src_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  cycle_o
);

  localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(RF_DEPTH - 1);
  localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(DM_DEPTH - 1);

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic [IDX_W-1:0]  oidx_q, oidx_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              fire;
  logic              busy;
  logic              load;

  dump_trigger #(
    .CNT_W(CNT_W)
  ) u_trigger (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mode_i      (mode_i),
    .trig_cycle_i(trig_cycle_i),
    .trig_ext_i  (trig_ext_i),
    .fire_o      (fire),
    .cycle_o     (cycle_o)
  );

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    data_d     = data_q;
    src_d      = src_q;
    oidx_d     = oidx_q;
    last_d     = last_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q | (fire & busy);
    rf_raddr_o = '0;
    dm_raddr_o = '0;
    // output register may take a new word whenever it is empty or draining
    load       = !valid_q || dump_ready_i;

    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = RF_SCAN;
          idx_d   = '0;
        end
      end
      RF_SCAN: begin
        rf_raddr_o = idx_q;
        if (load) begin
          valid_d = 1'b1;
          data_d  = rf_rdata_i;
          src_d   = SRC_RF;
          oidx_d  = idx_q;
          last_d  = 1'b0;
          if (idx_q == RF_LAST) begin
            state_d = DM_SCAN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DM_SCAN: begin
        dm_raddr_o = idx_q;
        if (load) begin
          valid_d = 1'b1;
          data_d  = dm_rdata_i;
          src_d   = SRC_DM;
          oidx_d  = idx_q;
          last_d  = (idx_q == DM_LAST);
          if (idx_q == DM_LAST) begin
            state_d = FINISH;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FINISH: begin
        if (dump_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      src_q     <= 1'b0;
      oidx_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      src_q     <= src_d;
      oidx_q    <= oidx_d;
      last_q    <= last_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign dump_valid_o = valid_q;
  assign dump_data_o  = data_q;
  assign dump_src_o   = src_q;
  assign dump_idx_o   = oidx_q;
  assign dump_last_o  = last_q;
  assign busy_o       = busy;
  assign done_o       = done_q;
  assign overrun_o    = overrun_q;

endmodule
